reg_file: RTL and testbench

//  - 8-entry x 16-bit general-purpose register file for the 16-bit single-cycle RISC CPU datapath.
//  - Two asynchronous read ports (RR1->RD1, RR2->RD2) feed the ALU operands.
//  - One synchronous write port (WR/WD/WEn) takes the writeback result.
//  - All entries are ordinary storage. R0 is NOT hardwired to zero.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/reg_cell.sv | 34 +++
 rtl/reg_file.sv | 43 ++++
 tb/tb_reg_file.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for the 16-bit single-cycle RISC CPU.
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage : cpu_pkg

// File: rtl/reg_cell.sv
// One DATA_W-bit architectural register with synchronous active-low clear and load enable.
module reg_cell
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    always_comb begin
        // NOTE: the hold value is assigned first, so every path writes data_d and no latch is inferred.
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    // NOTE: state is updated with <= so all cells sample their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : reg_cell

// File: rtl/reg_file.sv
// 8 x 16 register file: one synchronous write port, two combinational read ports, no write bypass.
module reg_file
    import cpu_pkg::*;
(
    input  logic              CLK,
    input  logic              CLR,
    input  logic              WEn,
    input  logic [ADDR_W-1:0] WR,
    input  logic [DATA_W-1:0] WD,
    input  logic [ADDR_W-1:0] RR1,
    input  logic [ADDR_W-1:0] RR2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    logic [NUM_REGS-1:0] wr_sel;
    reg_data_t           regs [NUM_REGS];

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = WEn && (WR == reg_addr_t'(i));
        end
    end

    // NOTE: every register, R0 included, is cleared on reset; the storage is flops, not a RAM macro.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        reg_cell u_cell (
            .clk   (CLK),
            .clr_n (CLR),
            .en    (wr_sel[i]),
            .d     (WD),
            .q     (regs[i])
        );
    end

    // Reads see the stored value only, so a same-cycle write shows up after the edge.
    always_comb begin
        RD1 = regs[RR1];
        RD2 = regs[RR2];
    end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected read data, a negedge monitor checks it.
module tb_reg_file;
    import cpu_pkg::*;

    logic              CLK;
    logic              CLR;
    logic              WEn;
    logic [ADDR_W-1:0] WR;
    logic [DATA_W-1:0] WD;
    logic [ADDR_W-1:0] RR1;
    logic [ADDR_W-1:0] RR2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;

    typedef struct {
        string             name;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    reg_file dut (
        .CLK (CLK),
        .CLR (CLR),
        .WEn (WEn),
        .WR  (WR),
        .WD  (WD),
        .RR1 (RR1),
        .RR2 (RR2),
        .RD1 (RD1),
        .RD2 (RD2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // Monitor: read data is sampled mid-cycle, after the inputs driven at posedge+1 have settled.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".rd1"}, RD1, e.e1);
            check({e.name, ".rd2"}, RD2, e.e2);
        end
    end

    // One clock cycle: drive every input just after the edge; the expectation describes the
    // register state produced by that edge, i.e. before this cycle's own write lands.
    task automatic cycle(input string name, input bit do_chk, input logic clr, input logic wen,
                         input logic [ADDR_W-1:0] wr, input logic [DATA_W-1:0] wd,
                         input logic [ADDR_W-1:0] rr1, input logic [ADDR_W-1:0] rr2,
                         input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2);
        exp_t e;
        @(posedge CLK);
        #1;
        CLR = clr;
        WEn = wen;
        WR  = wr;
        WD  = wd;
        RR1 = rr1;
        RR2 = rr2;
        if (do_chk) begin
            e.name = name;
            e.e1   = e1;
            e.e2   = e2;
            sb.push_back(e);
        end
    endtask

    logic [DATA_W-1:0] wvals [NUM_REGS] = '{16'h3C5A, 16'h0001, 16'h8000, 16'hFFFF,
                                            16'h1234, 16'hA5A5, 16'h7FFE, 16'h5555};

    initial begin
        CLR = 1'b0;
        WEn = 1'b1;
        WR  = '0;
        WD  = 16'hFFFF;
        RR1 = '0;
        RR2 = '0;

        // Reset held for 6 edges while a write of 0xFFFF is attempted every cycle.
        for (int i = 0; i < 6; i++) begin
            cycle($sformatf("rst_hold%0d", i), 1'b1, 1'b0, 1'b1, ADDR_W'(i), 16'hFFFF,
                  ADDR_W'(i), ADDR_W'(7 - i), 16'h0000, 16'h0000);
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            cycle($sformatf("rst_sweep%0d", i), 1'b1, 1'b1, 1'b0, '0, 16'hFFFF,
                  ADDR_W'(i), ADDR_W'(i + 3), 16'h0000, 16'h0000);
        end

        cycle("wr0_pre",     1'b1, 1'b1, 1'b1, 3'd0, 16'h0008, 3'd0, 3'd1, 16'h0000, 16'h0000);
        cycle("wr0_post",    1'b1, 1'b1, 1'b0, 3'd1, 16'h0020, 3'd0, 3'd1, 16'h0008, 16'h0000);
        cycle("wen0_r1",     1'b1, 1'b1, 1'b1, 3'd5, 16'h0500, 3'd0, 3'd1, 16'h0008, 16'h0000);
        cycle("wr5_wen0_r7", 1'b1, 1'b1, 1'b0, 3'd7, 16'h4000, 3'd5, 3'd7, 16'h0500, 16'h0000);
        cycle("r7_pre",      1'b1, 1'b1, 1'b1, 3'd7, 16'h4000, 3'd5, 3'd7, 16'h0500, 16'h0000);
        cycle("r7_post",     1'b1, 1'b1, 1'b1, 3'd3, 16'h1111, 3'd7, 3'd7, 16'h4000, 16'h4000);
        cycle("rdw_before",  1'b1, 1'b1, 1'b1, 3'd3, 16'h2222, 3'd3, 3'd3, 16'h1111, 16'h1111);
        cycle("rdw_after",   1'b1, 1'b1, 1'b0, 3'd3, 16'h0000, 3'd3, 3'd0, 16'h2222, 16'h0008);

        cycle("rstpri_pre",  1'b1, 1'b0, 1'b1, 3'd2, 16'hABCD, 3'd2, 3'd5, 16'h0000, 16'h0500);
        cycle("rstpri_r2",   1'b1, 1'b1, 1'b0, 3'd2, 16'hABCD, 3'd2, 3'd5, 16'h0000, 16'h0000);
        cycle("rstpri_r3r7", 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd7, 16'h0000, 16'h0000);

        // Distinct value in every register to expose decode or read-mux mix-ups.
        for (int i = 0; i < NUM_REGS; i++) begin
            cycle("fill", 1'b0, 1'b1, 1'b1, ADDR_W'(i), wvals[i], '0, '0, '0, '0);
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            cycle($sformatf("fill_rd%0d", i), 1'b1, 1'b1, 1'b0, '0, 16'hDEAD,
                  ADDR_W'(i), ADDR_W'(7 - i), wvals[i], wvals[7 - i]);
        end

        begin
            int budget;
            budget = 20;
            while (sb.size() > 0 && budget > 0) begin
                @(posedge CLK);
                budget--;
            end
            if (sb.size() > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain: %0d expectations left, expected 0", sb.size());
            end
        end
        @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file
